trng_collector: RTL and testbench

- Receiving end of the trng_top random_bit/random_valid stream.
- Runs a repetition-count health test on the raw bits and can apply optional von Neumann debiasing.
- Packs accepted bits into WORD_W-bit words and buffers them in a small FIFO.
- Presents the words to a system consumer over a valid/ready handshake.
- Sits directly behind trng_top, one instance per TRNG.

---
 rtl/trng_collector.sv | 155 +++++++++++++++
 tb/tb_trng_collector.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/trng_collector.sv
// TRNG bit collector: repetition-count health test, optional von Neumann
// debiasing, LSB-first word packing and a first-word-fall-through word FIFO.
module trng_collector #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned REP_LIMIT  = 32,
  parameter bit          DEBIAS     = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            random_bit,
  input  logic                            random_valid,
  output logic [WORD_W-1:0]               word_data,
  output logic                            word_valid,
  input  logic                            word_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            health_fail,
  output logic                            overflow,
  input  logic                            clear_fail
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BIT_W = $clog2(WORD_W);
  localparam int unsigned RUN_W = $clog2(REP_LIMIT + 1);

  logic [WORD_W-1:0] acc;
  logic [BIT_W-1:0]  bit_cnt;
  logic [RUN_W-1:0]  run_cnt;
  logic              last_bit;
  logic              have_last;
  logic              pair_valid;
  logic              pair_bit;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              sample;
  logic [RUN_W-1:0]  run_next;
  logic              trip;
  logic              emit;
  logic              emit_bit;
  logic [WORD_W-1:0] acc_next;
  logic              word_done;
  logic              pop;
  logic              full;
  logic              push_ok;

  // Sample qualification, health trip, debias and packing decode
  always_comb begin
    sample    = random_valid & enable & ~health_fail & ~clear_fail;
    run_next  = (have_last && (random_bit == last_bit)) ? run_cnt + RUN_W'(1) : RUN_W'(1);
    trip      = sample & (run_next == RUN_W'(REP_LIMIT));
    emit      = 1'b0;
    emit_bit  = random_bit;
    if (DEBIAS) begin
      emit     = sample & pair_valid & (pair_bit != random_bit) & ~trip;
      emit_bit = pair_bit;
    end else begin
      emit     = sample & ~trip;
    end
    acc_next           = acc;
    acc_next[bit_cnt]  = emit_bit;
    word_done          = emit & (bit_cnt == BIT_W'(WORD_W - 1));
    pop                = (count != CNT_W'(0)) & word_ready;
    full               = (count == CNT_W'(FIFO_DEPTH));
    push_ok            = word_done & (~full | pop);
  end

  // Health test, pair state and word accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= '0;
      bit_cnt     <= '0;
      run_cnt     <= '0;
      last_bit    <= 1'b0;
      have_last   <= 1'b0;
      pair_valid  <= 1'b0;
      pair_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (clear_fail) begin
        health_fail <= 1'b0;
      end else if (trip) begin
        health_fail <= 1'b1;
      end

      if (clear_fail || !enable || trip) begin
        acc        <= '0;
        bit_cnt    <= '0;
        run_cnt    <= '0;
        have_last  <= 1'b0;
        pair_valid <= 1'b0;
      end else if (sample) begin
        last_bit  <= random_bit;
        have_last <= 1'b1;
        run_cnt   <= run_next;
        if (!pair_valid) begin
          pair_valid <= 1'b1;
          pair_bit   <= random_bit;
        end else begin
          pair_valid <= 1'b0;
        end
        if (emit) begin
          if (word_done) begin
            acc     <= '0;
            bit_cnt <= '0;
          end else begin
            acc     <= acc_next;
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
      end
    end
  end

  // Word FIFO; a full FIFO drops the new word unless the head pops this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= acc_next;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push_ok && pop) begin
        count <= count - CNT_W'(1);
      end
      if (clear_fail) begin
        overflow <= 1'b0;
      end else if (word_done && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign word_data  = mem[rd_ptr];
  assign word_valid = (count != CNT_W'(0));
  assign fifo_count = count;

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector: one raw-packing instance and one
// debiasing instance, both WORD_W=8, driven from shared stimulus.
module tb_trng_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       random_bit;
  logic       random_valid;
  logic       word_ready;
  logic       clear_fail;

  logic [7:0] w0_data, w1_data;
  logic       w0_valid, w1_valid;
  logic [2:0] w0_count, w1_count;
  logic       w0_fail, w1_fail;
  logic       w0_ovf, w1_ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trng_collector #(.WORD_W(8), .FIFO_DEPTH(4), .REP_LIMIT(32), .DEBIAS(1'b0)) u_raw (
    .clk(clk), .rst(rst), .enable(enable), .random_bit(random_bit),
    .random_valid(random_valid), .word_data(w0_data), .word_valid(w0_valid),
    .word_ready(word_ready), .fifo_count(w0_count), .health_fail(w0_fail),
    .overflow(w0_ovf), .clear_fail(clear_fail)
  );

  trng_collector #(.WORD_W(8), .FIFO_DEPTH(4), .REP_LIMIT(32), .DEBIAS(1'b1)) u_vn (
    .clk(clk), .rst(rst), .enable(enable), .random_bit(random_bit),
    .random_valid(random_valid), .word_data(w1_data), .word_valid(w1_valid),
    .word_ready(word_ready), .fifo_count(w1_count), .health_fail(w1_fail),
    .overflow(w1_ovf), .clear_fail(clear_fail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Presents one raw bit for exactly one rising edge
  task automatic send(input logic b);
    random_valid = 1'b1;
    random_bit   = b;
    @(negedge clk);
    random_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send(w[i]);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; random_bit = 1'b0; random_valid = 1'b0;
    word_ready = 1'b0; clear_fail = 1'b0;
    do_reset();
    check("reset_valid", 32'(w0_valid), 32'h0);
    check("reset_count", 32'(w0_count), 32'h0);
    check("reset_fail", 32'(w0_fail), 32'h0);
    check("reset_ovf", 32'(w0_ovf), 32'h0);

    // 1: raw packing, LSB first
    for (int i = 0; i < 7; i++) send(1'(i % 2));
    check("t1_not_yet", 32'(w0_valid), 32'h0);
    send(1'b1);
    check("t1_valid", 32'(w0_valid), 32'h1);
    check("t1_data", 32'(w0_data), 32'hAA);
    check("t1_count", 32'(w0_count), 32'h1);

    // 2: von Neumann pairs with equal pairs and gaps mixed in
    do_reset();
    send(0); send(1);
    send(1); send(1);
    idle(2);
    send(0); send(1);
    send(0); send(0);
    send(0); idle(1); send(1);
    send(0); send(1);
    check("t2_zeros_pending", 32'(w1_count), 32'h0);
    send(1); send(0);
    send(1); send(1);
    send(1); send(0);
    idle(3);
    send(0); send(0);
    send(1); idle(2); send(0);
    check("t2_not_yet", 32'(w1_valid), 32'h0);
    send(1); send(0);
    check("t2_count", 32'(w1_count), 32'h1);
    check("t2_data", 32'(w1_data), 32'hF0);

    // 3: repetition test at the limit and one short of it
    do_reset();
    word_ready = 1'b1;
    for (int i = 0; i < 31; i++) send(1);
    send(0);
    check("t3_31_ok", 32'(w0_fail), 32'h0);
    for (int i = 0; i < 31; i++) send(1);
    check("t3_31_again_ok", 32'(w0_fail), 32'h0);
    send(1);
    check("t3_trip", 32'(w0_fail), 32'h1);
    idle(2);
    word_ready = 1'b0;
    check("t3_drained", 32'(w0_count), 32'h0);
    for (int i = 0; i < 8; i++) send(1'(i % 2));
    check("t3_ignored", 32'(w0_count), 32'h0);
    check("t3_sticky", 32'(w0_fail), 32'h1);
    clear_fail = 1'b1; random_valid = 1'b1; random_bit = 1'b1;
    @(negedge clk);
    clear_fail = 1'b0; random_valid = 1'b0;
    check("t3_cleared", 32'(w0_fail), 32'h0);
    send_word(8'h5A);
    check("t3_restart_count", 32'(w0_count), 32'h1);
    check("t3_restart_data", 32'(w0_data), 32'h5A);

    // 4: overflow, then simultaneous push and pop at full
    do_reset();
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    check("t4_full", 32'(w0_count), 32'h4);
    check("t4_no_ovf", 32'(w0_ovf), 32'h0);
    send_word(8'h55);
    check("t4_count", 32'(w0_count), 32'h4);
    check("t4_ovf", 32'(w0_ovf), 32'h1);
    check("t4_head", 32'(w0_data), 32'h11);
    for (int i = 0; i < 7; i++) send(1'((8'h66 >> i) & 8'h1));
    word_ready = 1'b1;
    send(1'b0);
    check("t4_pushpop_count", 32'(w0_count), 32'h4);
    check("t4_ovf_sticky", 32'(w0_ovf), 32'h1);
    check("t4_pop0", 32'(w0_data), 32'h22); idle(1);
    check("t4_pop1", 32'(w0_data), 32'h33); idle(1);
    check("t4_pop2", 32'(w0_data), 32'h44); idle(1);
    check("t4_pop3", 32'(w0_data), 32'h66); idle(1);
    check("t4_empty", 32'(w0_valid), 32'h0);
    word_ready = 1'b0;

    // 5: asynchronous reset mid-word
    do_reset();
    send_word(8'h12); send_word(8'h34); send_word(8'h56);
    send(1); send(1); send(0);
    check("t5_queued", 32'(w0_count), 32'h3);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_valid", 32'(w0_valid), 32'h0);
    check("t5_rst_count", 32'(w0_count), 32'h0);
    check("t5_rst_fail", 32'(w0_fail), 32'h0);
    check("t5_rst_ovf", 32'(w0_ovf), 32'h0);
    check("t5_rst_data", 32'(w0_data), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    send_word(8'hC3);
    check("t5_post_count", 32'(w0_count), 32'h1);
    check("t5_post_data", 32'(w0_data), 32'hC3);

    // 6: enable drop discards the partial word but keeps the FIFO
    do_reset();
    send_word(8'h9F);
    send(1); send(0); send(1); send(1); send(0);
    enable = 1'b0;
    send(1); idle(2);
    check("t6_held", 32'(w0_count), 32'h1);
    enable = 1'b1;
    send_word(8'h3C);
    check("t6_count", 32'(w0_count), 32'h2);
    check("t6_head", 32'(w0_data), 32'h9F);
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    check("t6_second", 32'(w0_data), 32'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
